// File: rtl/osc_freq_counter.sv
// rtl/osc_freq_counter.sv - gated, averaged rising-edge counter for one antenna oscillator
module osc_freq_counter #(
    parameter int OUT_B       = 16,
    parameter int GATE_CYCLES = 50000,
    parameter int AVG_LOG2    = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             osc_in,
    output logic [OUT_B-1:0] out_data,
    output logic             out_valid,
    output logic             out_overflow
);

    localparam int GW = $clog2(GATE_CYCLES);
    localparam int AW = OUT_B + AVG_LOG2;
    localparam int WW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
    localparam logic [WW-1:0]    WIN_LAST  = WW'((1 << AVG_LOG2) - 1);
    localparam logic [OUT_B-1:0] ONES      = '1;

    typedef enum logic {IDLE, COUNT} state_t;

    state_t state, state_nxt;
    logic counting, terminal;

    logic s1, s2, s3, osc_rise;

    logic [GW-1:0]    gate_cnt;
    logic [OUT_B-1:0] edge_cnt, cnt_inc, snapshot;
    logic             sat, sat_inc, snap_sat, acc_stb;

    logic [AW-1:0]    acc, acc_sum;
    logic [WW-1:0]    win_idx;
    logic             sticky_ovf, ovf_sum, win_last, fire;
    logic [OUT_B-1:0] final_data;
    logic             final_ovf, out_stb;

    // osc_in is asynchronous: two flops to resolve metastability, a third for edge detect
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= osc_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign osc_rise = s2 & ~s3;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (enable)  state_nxt = COUNT;
            COUNT:   if (!enable) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        counting = (state == COUNT);
        terminal = counting && (gate_cnt == GATE_LAST);
    end

    // The count including this cycle's edge; an edge at all-ones marks the window saturated
    assign cnt_inc = (osc_rise && edge_cnt != ONES) ? edge_cnt + 1'b1 : edge_cnt;
    assign sat_inc = sat | (osc_rise & (edge_cnt == ONES));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gate_cnt <= '0;
            edge_cnt <= '0;
            sat      <= 1'b0;
            snapshot <= '0;
            snap_sat <= 1'b0;
            acc_stb  <= 1'b0;
        end else begin
            acc_stb <= terminal;
            if (terminal) begin
                snapshot <= cnt_inc;
                snap_sat <= sat_inc;
            end
            if (!counting || terminal) begin
                gate_cnt <= '0;
                edge_cnt <= '0;
                sat      <= 1'b0;
            end else begin
                gate_cnt <= gate_cnt + 1'b1;
                edge_cnt <= cnt_inc;
                sat      <= sat_inc;
            end
        end
    end

    assign acc_sum  = acc + AW'(snapshot);
    assign ovf_sum  = sticky_ovf | snap_sat;
    assign win_last = (win_idx == WIN_LAST);
    assign fire     = acc_stb && win_last;

    // A launched final window still produces its sample even if enable has dropped;
    // partial averages are discarded whenever the FSM is idle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc        <= '0;
            sticky_ovf <= 1'b0;
            win_idx    <= '0;
            final_data <= '0;
            final_ovf  <= 1'b0;
            out_stb    <= 1'b0;
        end else begin
            out_stb <= fire;
            if (fire) begin
                final_data <= acc_sum[AW-1 -: OUT_B];
                final_ovf  <= ovf_sum;
            end
            if (!counting || fire) begin
                acc        <= '0;
                sticky_ovf <= 1'b0;
                win_idx    <= '0;
            end else if (acc_stb) begin
                acc        <= acc_sum;
                sticky_ovf <= ovf_sum;
                win_idx    <= win_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_data     <= '0;
            out_valid    <= 1'b0;
            out_overflow <= 1'b0;
        end else begin
            out_valid <= out_stb;
            if (out_stb) begin
                out_data     <= final_ovf ? ONES : final_data;
                out_overflow <= final_ovf;
            end
        end
    end

endmodule
